// File: rtl/ras_rbk_ctrl.sv
`default_nettype none
// ============================================================================
// ras_rbk_ctrl : RAS call-stack rollback controller (snapshot pipe + FSM)
// Rev 1.0
// ============================================================================

`ifndef RAS_DPT
`define RAS_DPT 8
`endif

module ras_rbk_ctrl #(
  parameter int ST_DPT     = `RAS_DPT,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16,
  localparam int ST_PTRW   = $clog2(ST_DPT)
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [ST_PTRW-1:0] i_snap_ptr,
  input  logic               i_snap_full,
  input  logic               i_fu_valid,
  input  logic               i_fu_is_call,
  input  logic               i_fu_flush,
  input  logic               i_du_stall,
  input  logic               i_exu_stall,
  input  logic               i_exu_flush,
  output logic               o_st_rbk_en,
  output logic [ST_PTRW-1:0] o_st_rbk_ptr,
  output logic               o_st_rbk_full,
  output logic               o_st_rbk_incr_ptr,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_rbk_cnt
);

  localparam logic [3:0] C_SETTLE_INIT = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RBK    = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         settle_cnt_q, settle_cnt_d;

  logic               d_valid_q, d_valid_d;
  logic [ST_PTRW-1:0] d_ptr_q, d_ptr_d;
  logic               d_full_q, d_full_d;
  logic               d_call_q, d_call_d;

  logic               x_valid_q, x_valid_d;
  logic [ST_PTRW-1:0] x_ptr_q, x_ptr_d;
  logic               x_full_q, x_full_d;
  logic               x_call_q, x_call_d;

  logic [ST_PTRW-1:0] rbk_ptr_q, rbk_ptr_d;
  logic               rbk_full_q, rbk_full_d;
  logic               rbk_incr_q, rbk_incr_d;
  logic [CNT_W-1:0]   rbk_cnt_q, rbk_cnt_d;

  logic               w_flush_acc;

  // A flush only counts when the X slot actually holds a live instruction.
  assign w_flush_acc = i_exu_flush & x_valid_q;

  // Snapshot pipeline: the accepted flush kills both slots over any load/hold.
  always_comb begin
    d_valid_d = d_valid_q;
    d_ptr_d   = d_ptr_q;
    d_full_d  = d_full_q;
    d_call_d  = d_call_q;
    x_valid_d = x_valid_q;
    x_ptr_d   = x_ptr_q;
    x_full_d  = x_full_q;
    x_call_d  = x_call_q;

    if (!i_du_stall) begin
      d_valid_d = i_fu_valid & ~i_fu_flush;
      d_ptr_d   = i_snap_ptr;
      d_full_d  = i_snap_full;
      d_call_d  = i_fu_is_call;
    end
    if (!i_exu_stall) begin
      x_valid_d = d_valid_q;
      x_ptr_d   = d_ptr_q;
      x_full_d  = d_full_q;
      x_call_d  = d_call_q;
    end
    if (w_flush_acc) begin
      d_valid_d = 1'b0;
      x_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    rbk_ptr_d    = rbk_ptr_q;
    rbk_full_d   = rbk_full_q;
    rbk_incr_d   = rbk_incr_q;
    rbk_cnt_d    = rbk_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_flush_acc) state_d = ST_RBK;
      end
      ST_RBK: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = C_SETTLE_INIT;
        if (rbk_cnt_q != {CNT_W{1'b1}}) rbk_cnt_d = rbk_cnt_q + 1'b1;
      end
      ST_SETTLE: begin
        if (w_flush_acc) begin
          state_d = ST_RBK;
        end else if (settle_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fields are captured on every accepted flush; they hold otherwise.
    if (w_flush_acc) begin
      rbk_ptr_d  = x_ptr_q;
      rbk_full_d = x_full_q;
      rbk_incr_d = x_call_q;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 4'd0;
      d_valid_q    <= 1'b0;
      d_ptr_q      <= '0;
      d_full_q     <= 1'b0;
      d_call_q     <= 1'b0;
      x_valid_q    <= 1'b0;
      x_ptr_q      <= '0;
      x_full_q     <= 1'b0;
      x_call_q     <= 1'b0;
      rbk_ptr_q    <= '0;
      rbk_full_q   <= 1'b0;
      rbk_incr_q   <= 1'b0;
      rbk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      d_valid_q    <= d_valid_d;
      d_ptr_q      <= d_ptr_d;
      d_full_q     <= d_full_d;
      d_call_q     <= d_call_d;
      x_valid_q    <= x_valid_d;
      x_ptr_q      <= x_ptr_d;
      x_full_q     <= x_full_d;
      x_call_q     <= x_call_d;
      rbk_ptr_q    <= rbk_ptr_d;
      rbk_full_q   <= rbk_full_d;
      rbk_incr_q   <= rbk_incr_d;
      rbk_cnt_q    <= rbk_cnt_d;
    end
  end

  assign o_st_rbk_en       = (state_q == ST_RBK);
  assign o_busy            = (state_q != ST_IDLE);
  assign o_st_rbk_ptr      = rbk_ptr_q;
  assign o_st_rbk_full     = rbk_full_q;
  assign o_st_rbk_incr_ptr = rbk_incr_q;
  assign o_rbk_cnt         = rbk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ras_rbk_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ras_rbk_ctrl : directed bench for ras_rbk_ctrl (CNT_W=16 and CNT_W=4)
// Rev 1.0
// ============================================================================
module tb_ras_rbk_ctrl;

  logic       clk;
  logic       aresetn;
  logic [2:0] i_snap_ptr;
  logic       i_snap_full, i_fu_valid, i_fu_is_call, i_fu_flush;
  logic       i_du_stall, i_exu_stall, i_exu_flush;

  logic       en_a, full_a, incr_a, busy_a;
  logic [2:0] ptr_a;
  logic [15:0] cnt_a;
  logic       en_b, full_b, incr_b, busy_b;
  logic [2:0] ptr_b;
  logic [3:0] cnt_b;

  int n_vec;
  int n_err;

  ras_rbk_ctrl #(.ST_DPT(8), .SETTLE_CYC(2), .CNT_W(16)) u_dut (
    .clk(clk), .aresetn(aresetn),
    .i_snap_ptr(i_snap_ptr), .i_snap_full(i_snap_full), .i_fu_valid(i_fu_valid),
    .i_fu_is_call(i_fu_is_call), .i_fu_flush(i_fu_flush), .i_du_stall(i_du_stall),
    .i_exu_stall(i_exu_stall), .i_exu_flush(i_exu_flush),
    .o_st_rbk_en(en_a), .o_st_rbk_ptr(ptr_a), .o_st_rbk_full(full_a),
    .o_st_rbk_incr_ptr(incr_a), .o_busy(busy_a), .o_rbk_cnt(cnt_a)
  );

  ras_rbk_ctrl #(.ST_DPT(8), .SETTLE_CYC(2), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .aresetn(aresetn),
    .i_snap_ptr(i_snap_ptr), .i_snap_full(i_snap_full), .i_fu_valid(i_fu_valid),
    .i_fu_is_call(i_fu_is_call), .i_fu_flush(i_fu_flush), .i_du_stall(i_du_stall),
    .i_exu_stall(i_exu_stall), .i_exu_flush(i_exu_flush),
    .o_st_rbk_en(en_b), .o_st_rbk_ptr(ptr_b), .o_st_rbk_full(full_b),
    .o_st_rbk_incr_ptr(incr_b), .o_busy(busy_b), .o_rbk_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [2:0] ptr, input logic full, input logic call);
    i_fu_valid   = 1'b1;
    i_snap_ptr   = ptr;
    i_snap_full  = full;
    i_fu_is_call = call;
  endtask

  // Fetch a snapshot, walk it into X, flush, and let the controller settle.
  task automatic full_rollback(input logic [2:0] ptr);
    fetch(ptr, 1'b0, 1'b0);
    tick();
    i_fu_valid = 1'b0;
    tick();
    i_exu_flush = 1'b1;
    tick();
    check_val("loop_en", {31'd0, en_a}, 32'd1);
    i_exu_flush = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    aresetn = 1'b0;
    i_snap_ptr = '0; i_snap_full = 0; i_fu_valid = 0; i_fu_is_call = 0;
    i_fu_flush = 0; i_du_stall = 0; i_exu_stall = 0; i_exu_flush = 0;
    #12;
    check_val("rst_en",   {31'd0, en_a},   32'd0);
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_cnt",  {16'd0, cnt_a},  32'd0);
    aresetn = 1'b1;
    tick();

    // 1: plain non-call rollback, 1-cycle enable, 3 busy cycles
    fetch(3'd3, 1'b0, 1'b0);
    tick();
    i_fu_valid = 1'b0;
    tick();
    check_val("t1_pre_en", {31'd0, en_a}, 32'd0);
    i_exu_flush = 1'b1;
    tick();
    check_val("t1_en",   {31'd0, en_a},   32'd1);
    check_val("t1_ptr",  {29'd0, ptr_a},  32'd3);
    check_val("t1_full", {31'd0, full_a}, 32'd0);
    check_val("t1_incr", {31'd0, incr_a}, 32'd0);
    check_val("t1_busy1", {31'd0, busy_a}, 32'd1);
    i_exu_flush = 1'b0;
    tick();
    check_val("t1_en_off", {31'd0, en_a},  32'd0);
    check_val("t1_busy2", {31'd0, busy_a}, 32'd1);
    check_val("t1_ptr_hold", {29'd0, ptr_a}, 32'd3);
    tick();
    check_val("t1_busy3", {31'd0, busy_a}, 32'd1);
    tick();
    check_val("t1_busy_end", {31'd0, busy_a}, 32'd0);
    check_val("t1_cnt", {16'd0, cnt_a}, 32'd1);

    // 2: CALL snapshot
    fetch(3'd7, 1'b1, 1'b1);
    tick();
    i_fu_valid = 1'b0;
    tick();
    i_exu_flush = 1'b1;
    tick();
    check_val("t2_en",   {31'd0, en_a},   32'd1);
    check_val("t2_ptr",  {29'd0, ptr_a},  32'd7);
    check_val("t2_full", {31'd0, full_a}, 32'd1);
    check_val("t2_incr", {31'd0, incr_a}, 32'd1);
    i_exu_flush = 1'b0;
    tick(); tick(); tick();
    check_val("t2_cnt", {16'd0, cnt_a}, 32'd2);

    // 3: flush against an X slot holding a killed fetch
    fetch(3'd2, 1'b0, 1'b0);
    i_fu_flush = 1'b1;
    tick();
    i_fu_valid = 1'b0;
    i_fu_flush = 1'b0;
    tick();
    i_exu_flush = 1'b1;
    tick();
    check_val("t3_en",   {31'd0, en_a},   32'd0);
    check_val("t3_busy", {31'd0, busy_a}, 32'd0);
    i_exu_flush = 1'b0;
    tick();
    check_val("t3_cnt", {16'd0, cnt_a}, 32'd2);

    // 4: X held by stall at ptr 5 while D carries ptr 6
    fetch(3'd5, 1'b0, 1'b0);
    tick();
    fetch(3'd6, 1'b0, 1'b0);
    tick();
    i_fu_valid  = 1'b0;
    i_exu_stall = 1'b1;
    i_exu_flush = 1'b1;
    tick();
    check_val("t4_en",  {31'd0, en_a},  32'd1);
    check_val("t4_ptr", {29'd0, ptr_a}, 32'd5);
    i_exu_flush = 1'b0;
    i_exu_stall = 1'b0;
    tick(); tick(); tick();
    check_val("t4_idle", {31'd0, busy_a}, 32'd0);
    i_exu_flush = 1'b1;
    tick();
    check_val("t4_slots_dead1", {31'd0, en_a}, 32'd0);
    tick();
    check_val("t4_slots_dead2", {31'd0, en_a}, 32'd0);
    i_exu_flush = 1'b0;
    check_val("t4_cnt", {16'd0, cnt_a}, 32'd3);

    // 5: second flush accepted in the last SETTLE cycle
    fetch(3'd4, 1'b0, 1'b0);
    tick();
    i_fu_valid = 1'b0;
    tick();
    i_exu_flush = 1'b1;
    tick();
    check_val("t5_en1",  {31'd0, en_a},  32'd1);
    check_val("t5_ptr1", {29'd0, ptr_a}, 32'd4);
    i_exu_flush = 1'b0;
    fetch(3'd1, 1'b0, 1'b0);
    tick();
    check_val("t5_s1_busy", {31'd0, busy_a}, 32'd1);
    check_val("t5_s1_en",   {31'd0, en_a},   32'd0);
    i_fu_valid = 1'b0;
    tick();
    check_val("t5_s2_busy", {31'd0, busy_a}, 32'd1);
    i_exu_flush = 1'b1;
    tick();
    check_val("t5_en2",   {31'd0, en_a},   32'd1);
    check_val("t5_ptr2",  {29'd0, ptr_a},  32'd1);
    check_val("t5_busy2", {31'd0, busy_a}, 32'd1);
    i_exu_flush = 1'b0;
    tick();
    check_val("t5_en2_off", {31'd0, en_a}, 32'd0);
    tick(); tick();
    check_val("t5_idle", {31'd0, busy_a}, 32'd0);
    check_val("t5_cnt",  {16'd0, cnt_a},  32'd5);
    check_val("t5_cnt4", {28'd0, cnt_b},  32'd5);

    // 6: saturation of the 4-bit counter, then async reset during RBK
    for (int i = 0; i < 10; i++) full_rollback(3'(i));
    check_val("t6_cnt4_15", {28'd0, cnt_b}, 32'd15);
    full_rollback(3'd2);
    full_rollback(3'd3);
    check_val("t6_cnt4_sat", {28'd0, cnt_b}, 32'd15);
    check_val("t6_cnt16",    {16'd0, cnt_a}, 32'd17);

    fetch(3'd6, 1'b1, 1'b1);
    tick();
    i_fu_valid = 1'b0;
    tick();
    i_exu_flush = 1'b1;
    tick();
    check_val("t6_rbk_en",  {31'd0, en_a},  32'd1);
    check_val("t6_rbk_ptr", {29'd0, ptr_a}, 32'd6);
    i_exu_flush = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check_val("t6_rst_en",   {31'd0, en_a},   32'd0);
    check_val("t6_rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("t6_rst_ptr",  {29'd0, ptr_a},  32'd0);
    check_val("t6_rst_full", {31'd0, full_a}, 32'd0);
    check_val("t6_rst_incr", {31'd0, incr_a}, 32'd0);
    check_val("t6_rst_cnt",  {16'd0, cnt_a},  32'd0);
    check_val("t6_rst_cnt4", {28'd0, cnt_b},  32'd0);
    check_val("t6_rst_en4",  {31'd0, en_b},   32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    check_val("t6_post_busy", {31'd0, busy_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
